// File: rtl/spi_master_driver_pkg.sv
// Shared types and constants for the SPI master driver and its shift register.
package spi_master_driver_pkg;

  localparam int ADDR_SIZE = 8;
  localparam int MEM_WIDTH = 8;
  // Serial frame: 2 command bits followed by the payload.
  localparam int FRAME_LEN = ADDR_SIZE + 2;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } control_e;

  typedef enum logic [2:0] {
    M_IDLE, M_START, M_SHIFT, M_GAP, M_RECV, M_DONE
  } mstate_e;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_master_shreg.sv
// Parameterised PISO/SIPO shift register, MSB-first, with load priority over shift.
module spi_master_shreg #(
  parameter int W     = 8,
  parameter int OUT_W = W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [W-1:0]     load_val,
  input  logic             shift,
  input  logic             sin,
  output logic [OUT_W-1:0] q
);

  logic [W-1:0] sh_q, sh_d;

  // Next value: parallel load, else shift left with sin entering at the LSB.
  always_comb begin
    sh_d = sh_q;
    if (load)       sh_d = load_val;
    else if (shift) sh_d = {sh_q[W-2:0], sin};
  end

  // Register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh_q <= '0;
    else     sh_q <= sh_d;
  end

  // Expose only the upper OUT_W bits (1 for serial-out use, W for parallel-out use).
  assign q = sh_q[W-1 -: OUT_W];

endmodule

// File: rtl/spi_master_driver.sv
// Transaction-level SPI master: serialises {cmd, payload} frames onto SS_n/MOSI
// and, for RD_DATA, collects a byte from MISO after a configurable gap.
module spi_master_driver
  import spi_master_driver_pkg::*;
#(
  parameter int RD_GAP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_cmd,
  input  logic [ADDR_SIZE-1:0] req_data,
  output logic                 rsp_valid,
  output logic [MEM_WIDTH-1:0] rsp_data,
  output logic                 busy,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO
);

  localparam int CNT_MAX = max3(FRAME_LEN, RD_GAP, MEM_WIDTH);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SHIFT_LD = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'((RD_GAP > 0) ? RD_GAP - 1 : 0);
  localparam logic [CNT_W-1:0] RECV_LD  = CNT_W'(MEM_WIDTH - 1);

  mstate_e                state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rd_q, rd_d;
  logic                   ss_n_q, ss_n_d;
  logic                   mosi_q, mosi_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [MEM_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                   busy_q, busy_d;

  logic                   tx_load, tx_shift, rx_shift;
  logic                   tx_msb;
  logic [MEM_WIDTH-2:0]   rx_bits;

  // Outgoing frame: loaded on accept, MSB presented to MOSI each shift.
  spi_master_shreg #(.W(FRAME_LEN), .OUT_W(1)) u_tx (
    .clk(clk), .rst(rst), .load(tx_load), .load_val({req_cmd, req_data}),
    .shift(tx_shift), .sin(1'b0), .q(tx_msb)
  );

  // Incoming byte: holds the first MEM_WIDTH-1 bits; the final bit is taken
  // straight from MISO so the whole byte lands in rsp_data on the last edge.
  spi_master_shreg #(.W(MEM_WIDTH-1)) u_rx (
    .clk(clk), .rst(rst), .load(1'b0), .load_val('0),
    .shift(rx_shift), .sin(MISO), .q(rx_bits)
  );

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    ss_n_d      = 1'b0;
    mosi_d      = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    tx_load     = 1'b0;
    tx_shift    = 1'b0;
    rx_shift    = 1'b0;
    case (state_q)
      M_IDLE: begin
        ss_n_d = 1'b1;
        if (req_valid) begin
          state_d = M_START;
          tx_load = 1'b1;
          rd_d    = (req_cmd == RD_DATA);
          ss_n_d  = 1'b0;
          mosi_d  = req_cmd[1];
        end
      end
      M_START: begin
        state_d  = M_SHIFT;
        cnt_d    = SHIFT_LD;
        mosi_d   = tx_msb;
        tx_shift = 1'b1;
      end
      M_SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d    = cnt_q - CNT_W'(1);
          mosi_d   = tx_msb;
          tx_shift = 1'b1;
        end else if (rd_q) begin
          if (RD_GAP > 0) begin
            state_d = M_GAP;
            cnt_d   = GAP_LD;
          end else begin
            state_d = M_RECV;
            cnt_d   = RECV_LD;
          end
        end else begin
          state_d = M_DONE;
          cnt_d   = '0;
          ss_n_d  = 1'b1;
        end
      end
      M_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = M_RECV;
          cnt_d   = RECV_LD;
        end
      end
      M_RECV: begin
        rx_shift = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d     = M_DONE;
          cnt_d       = '0;
          ss_n_d      = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_data_d  = {rx_bits, MISO};
        end
      end
      M_DONE: begin
        state_d = M_IDLE;
        ss_n_d  = 1'b1;
      end
      default: begin
        state_d = M_IDLE;
        ss_n_d  = 1'b1;
      end
    endcase
    busy_d = (state_d != M_IDLE);
  end

  // FSM state, counter and registered outputs; reset aborts any frame at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= M_IDLE;
      cnt_q       <= '0;
      rd_q        <= 1'b0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = (state_q == M_IDLE);
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_master_driver.sv
// Bench for spi_master_driver: positional frame model checked every cycle,
// plus directed frames with literal MOSI/length/gap expectations.
module tb_spi_master_driver;
  import spi_master_driver_pkg::*;

  localparam int G = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_cmd = 2'b00;
  logic [7:0] req_data = 8'h00;
  logic       req_ready, rsp_valid, busy, SS_n, MOSI, MISO;
  logic [7:0] rsp_data;

  always #5 clk = ~clk;

  spi_master_driver #(.RD_GAP(G)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_data(req_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .busy(busy), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // ---------------- model: frame = position index 0..last ----------------
  // pos 0 start, 1..10 frame bits, then (reads) G gap cycles, 8 receive cycles; last = done.
  logic       m_idle = 1'b1;
  int         m_pos  = 0;
  logic [1:0] m_cmd  = 2'b00;
  logic [7:0] m_data = 8'h00;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] m_rd   = 8'h00;
  logic [7:0] miso_byte = 8'h00;
  logic       m_isrd;
  int         m_last;
  logic [9:0] m_frame;

  assign m_isrd  = (m_cmd == RD_DATA);
  assign m_last  = m_isrd ? (19 + G) : 11;
  assign m_frame = {m_cmd, m_data};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idle <= 1'b1;
      m_pos  <= 0;
      m_rd   <= 8'h00;
    end else if (m_idle) begin
      if (req_valid) begin
        m_idle <= 1'b0;
        m_pos  <= 0;
        m_cmd  <= req_cmd;
        m_data <= req_data;
        m_byte <= miso_byte;
      end
    end else begin
      if (m_pos == m_last) m_idle <= 1'b1;
      else                 m_pos  <= m_pos + 1;
      if (m_isrd && (m_pos + 1 == m_last)) m_rd <= m_byte;
    end
  end

  logic e_ss, e_mosi, e_miso, e_rv, e_busy, e_ready;
  always_comb begin
    e_ss    = 1'b1;
    e_mosi  = 1'b0;
    e_miso  = 1'b0;
    e_rv    = 1'b0;
    e_busy  = 1'b0;
    e_ready = 1'b1;
    if (!m_idle) begin
      e_ready = 1'b0;
      e_busy  = 1'b1;
      e_ss    = (m_pos == m_last);
      e_rv    = m_isrd && (m_pos == m_last);
      if (m_pos == 0)        e_mosi = m_cmd[1];
      else if (m_pos <= 10)  e_mosi = m_frame[10 - m_pos];
      if (m_isrd && m_pos >= 11 + G && m_pos <= 18 + G)
        e_miso = m_byte[7 - (m_pos - 11 - G)];
    end
  end

  assign MISO = e_miso;

  // Cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("ss_n", SS_n, e_ss);
    chk("mosi", MOSI, e_mosi);
    chk("busy", busy, e_busy);
    chk("req_ready", req_ready, e_ready);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("rsp_data", rsp_data, m_rd);
  end

  // ---------------- frame monitor ----------------
  int          len_q[$];
  logic [31:0] bits_q[$];
  int          gap_q[$];
  int          fr_len = 0;
  logic [31:0] fr_bits = 0;
  int          hi_run = 0;
  int          rv_cnt = 0;

  always @(negedge clk) begin
    if (!SS_n) begin
      fr_bits <= {fr_bits[30:0], MOSI};
      fr_len  <= fr_len + 1;
      if (hi_run > 0) gap_q.push_back(hi_run);
      hi_run  <= 0;
    end else begin
      if (fr_len > 0) begin
        len_q.push_back(fr_len);
        bits_q.push_back(fr_bits);
      end
      fr_len  <= 0;
      fr_bits <= 0;
      hi_run  <= hi_run + 1;
    end
    if (rsp_valid) rv_cnt <= rv_cnt + 1;
  end

  task automatic chk_frame(input string nm, input int exp_len, input logic [31:0] exp_bits);
    chk({nm, "_present"}, (len_q.size() > 0), 1);
    if (len_q.size() > 0) begin
      chk({nm, "_len"}, len_q.pop_front(), exp_len);
      chk({nm, "_mosi"}, bits_q.pop_front(), exp_bits);
    end
  endtask

  task automatic send(input logic [1:0] c, input logic [7:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_cmd = c; req_data = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || !SS_n) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", (n < 200), 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    // Reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ss_n", SS_n, 1);
    chk("rst_mosi", MOSI, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rv", rsp_valid, 0);
    len_q.delete(); bits_q.delete(); gap_q.delete();

    // WR_ADDR A5
    r0 = rv_cnt;
    send(WR_ADDR, 8'hA5);
    wait_idle();
    chk_frame("wr_a5", 11, 32'b00010100101);
    chk("wr_a5_rv", rv_cnt - r0, 0);

    // RD_DATA with 3C returned on MISO
    miso_byte = 8'h3C;
    r0 = rv_cnt;
    send(RD_DATA, 8'h00);
    wait_idle();
    chk_frame("rd", 20, 32'b11100000000000000000);
    chk("rd_rv_cnt", rv_cnt - r0, 1);
    chk("rd_byte", rsp_data, 8'h3C);

    // Back-to-back with request held high; payload changes right after accept
    gap_q.delete();
    @(negedge clk);
    req_valid = 1'b1; req_cmd = WR_ADDR; req_data = 8'h10;
    @(negedge clk);
    req_cmd = WR_DATA; req_data = 8'h77;
    repeat (13) @(negedge clk);
    req_valid = 1'b0;
    wait_idle();
    chk_frame("b2b1", 11, 32'b00000010000);
    chk_frame("b2b2", 11, 32'b00101110111);
    chk("b2b_gap", (gap_q.size() > 0) ? gap_q[gap_q.size()-1] : -1, 2);

    // Reset during bit 5 of an RD_DATA frame
    miso_byte = 8'hA5;
    r0 = rv_cnt;
    send(RD_DATA, 8'h5A);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ss_n", SS_n, 1);
    chk("mid_rst_data", rsp_data, 0);
    chk("mid_rst_ready", req_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid_rst_rv", rv_cnt - r0, 0);
    chk("mid_rst_data2", rsp_data, 0);
    len_q.delete(); bits_q.delete();

    // Requests during an active frame are ignored
    @(negedge clk);
    req_valid = 1'b1; req_cmd = WR_ADDR; req_data = 8'h3C;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_valid = (i % 2 == 0);
      req_cmd   = RD_ADDR;
      req_data  = 8'hFF;
    end
    req_valid = 1'b0;
    wait_idle();
    chk_frame("ign", 11, 32'b00000111100);
    chk("ign_extra_frames", len_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master_driver.md
Name: spi_master_driver

Overview:
- Transaction-level SPI master that sits directly upstream of the SPI slave / single-port RAM pair and generates its serial frames.
- Accepts one command per handshake: a control code (WR_ADDR, WR_DATA, RD_ADDR or RD_DATA) plus an 8-bit payload.
- Serialises each command onto SS_n/MOSI. For RD_DATA it also deserialises the returned byte from MISO.
- Used as the RTL stimulus engine in block- and system-level benches, and as the on-chip host for the slave.

Parameters:
- ADDR_SIZE, 8, payload width; the frame carries 2 command bits plus ADDR_SIZE bits.
- MEM_WIDTH, 8, width of the read-back byte sampled from MISO.
- RD_GAP, 1, idle cycles (SS_n low, MOSI 0) between the last MOSI bit and the first MISO sample of an RD_DATA frame; legal range 0..7.

Ports:
- clk  in  1  system clock; the SPI bit rate equals the clk rate.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  command request.
- req_ready  out  1  master can accept; high only in M_IDLE.
- req_cmd  in  2  control_e code.
- req_data  in  ADDR_SIZE  address or write-data payload.
- rsp_valid  out  1  one-cycle pulse: read byte available.
- rsp_data  out  MEM_WIDTH  read byte; held until the next rsp_valid.
- busy  out  1  high while a frame is in progress (any state other than M_IDLE).
- SS_n  out  1  slave select, active low.
- MOSI  out  1  serial data to the slave.
- MISO  in  1  serial data from the slave.

Behaviour:
- Reset (asynchronous, active-high) forces state M_IDLE and sets: SS_n=1, MOSI=0, rsp_valid=0, rsp_data=0, busy=0, req_ready=1. All outputs except req_ready are registered.
- Accept:
  - A transaction is accepted on the rising edge where req_valid && req_ready.
  - On that edge, the 10-bit shift register loads {req_cmd, req_data}, and the command is latched for the RD_DATA decision.
  - req_valid is ignored while req_ready is low.
- States and transitions:
  - M_IDLE: SS_n=1. On accept, go to M_START.
  - M_START: 1 cycle. SS_n=0, MOSI=req_cmd[1] (lead bit: 0 selects the write path, 1 selects the read path).
  - M_SHIFT: ADDR_SIZE+2 cycles. SS_n=0. MOSI carries the frame MSB-first, cmd[1], cmd[0], data[7]..data[0]. Afterwards go to M_GAP if the command is RD_DATA, otherwise to M_DONE.
  - M_GAP: RD_GAP cycles. SS_n=0, MOSI=0. If RD_GAP=0 this state is skipped.
  - M_RECV: MEM_WIDTH cycles. SS_n=0, MOSI=0. MISO is sampled on each rising edge, MSB-first, into the receive shift register.
  - M_DONE: 1 cycle. SS_n=1, MOSI=0, busy=1. For RD_DATA only: rsp_data<=received byte and rsp_valid=1 in this cycle. Then go to M_IDLE.
- Timing:
  - SS_n low for exactly 11 cycles on non-read frames and 11+RD_GAP+MEM_WIDTH cycles on RD_DATA frames.
  - SS_n is always high for at least 2 cycles between frames (M_DONE plus M_IDLE).
- Counters: a single down-counter, wide enough for max(ADDR_SIZE+2, RD_GAP, MEM_WIDTH). It reloads on every state entry and must not wrap.
- Back-to-back: a request held high through M_DONE is accepted in the following M_IDLE cycle. Maximum throughput is one frame per 13 cycles (non-read).
- Reset mid-frame:
  - SS_n returns high immediately (asynchronously); the frame is aborted.
  - No rsp_valid is produced, and rsp_data is cleared to 0.
- req_cmd and req_data may change after acceptance with no effect on the current frame.
- MISO is don't-care outside M_RECV.

Decomposition:
- Into shared_pkg add the master state enum: M_IDLE, M_START, M_SHIFT, M_GAP, M_RECV, M_DONE.
- control_e, ADDR_SIZE and MEM_WIDTH are reused from shared_pkg; the frame length (ADDR_SIZE+2) is defined there as a constant.
- One natural sub-module, spi_master_shreg: a parameterised PISO/SIPO shift register with load/shift enables, used for both the MOSI and MISO paths.

Test Plan:
- Reset values: assert rst for 3 cycles, then deassert -> SS_n=1, MOSI=0, req_ready=1, busy=0, rsp_valid=0.
- WR_ADDR frame: req_cmd=WR_ADDR, req_data=8'hA5 -> SS_n low for 11 cycles. MOSI = 0 then 0,0,1,0,1,0,0,1,0,1. No rsp_valid.
- RD_DATA frame: RD_GAP=1, req_cmd=RD_DATA, req_data=8'h00, MISO driven with 8'h3C during M_RECV -> SS_n low for 20 cycles, rsp_valid pulses once, rsp_data=8'h3C.
- Back-to-back: req_valid held high with WR_ADDR 8'h10 then WR_DATA 8'h77 -> two frames separated by exactly 2 SS_n-high cycles. Frame 2 MOSI = 0,0,1,0,1,1,1,0,1,1,1.
- Reset mid-frame: assert rst during bit 5 of an RD_DATA frame -> SS_n=1 in the same cycle, no rsp_valid afterwards, rsp_data=0, req_ready=1.
- Request ignored while busy: toggle req_valid with RD_ADDR 8'hFF during an active frame -> no second frame starts until M_IDLE. Current frame MOSI is unchanged.
